// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array feeder.
// Lane i of a word occupies bits [LW-1-W*i -: W].
package systolic_pkg;

  localparam int N           = 4;
  localparam int W           = 8;
  localparam int LW          = N * W;
  localparam int RW          = N * N * W;
  localparam int FEED_CYCLES = 2 * N - 1;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    WAIT,
    HOLD
  } state_t;

  function automatic int lane_lsb(input int i);
    return LW - W * (i + 1);
  endfunction

  function automatic logic [W-1:0] lane_get(
    input logic [LW-1:0] word,
    input int            i
  );
    return word[lane_lsb(i) +: W];
  endfunction

endpackage

// File: rtl/systolic_skew_mux.sv
// Builds one diagonally skewed lane word for feed step t.
// Lane l carries element l of diagonal t: row-major m[l][t-l], column-major m[t-l][l].
module systolic_skew_mux
  import systolic_pkg::*;
#(
  parameter bit COL_MAJOR = 1'b0
) (
  input  logic [2:0]    i_t,
  input  logic [W-1:0]  i_m [N][N],
  output logic [LW-1:0] o_word
);

  // Select the in-range element for every lane, zero elsewhere
  always_comb begin
    logic [2:0] w_k;
    o_word = '0;
    w_k    = '0;
    for (int l = 0; l < N; l++) begin
      w_k = i_t - 3'(l);
      if (i_t >= 3'(l) && w_k < 3'(N)) begin
        if (COL_MAJOR)
          o_word[lane_lsb(l) +: W] = i_m[w_k[1:0]][2'(l)];
        else
          o_word[lane_lsb(l) +: W] = i_m[2'(l)][w_k[1:0]];
      end
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// Buffers A/B, streams them skewed into the 4x4 array, owns the array reset
// and returns the captured result over a valid/ready port.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int WAIT_MAX = 8
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_load_valid,
  output logic          o_load_ready,
  input  logic          i_load_sel,
  input  logic [1:0]    i_load_row,
  input  logic [LW-1:0] i_load_data,
  input  logic          i_start,
  output logic          o_busy,
  output logic          o_err,
  output logic          o_arr_reset_n,
  output logic [LW-1:0] o_inA,
  output logic [LW-1:0] o_inB,
  input  logic          i_arr_done,
  input  logic [RW-1:0] i_result_in,
  output logic [RW-1:0] o_result_out,
  output logic          o_result_valid,
  input  logic          i_result_ready
);

  state_t        r_state, w_next;
  logic [2:0]    r_t, w_t_next;
  logic [3:0]    r_wcnt;
  logic [W-1:0]  r_a [N][N];
  logic [W-1:0]  r_b [N][N];
  logic [W-1:0]  w_a_nxt [N][N];
  logic [W-1:0]  w_b_nxt [N][N];
  logic [LW-1:0] w_skew_a, w_skew_b;
  logic [LW-1:0] r_inA, r_inB;
  logic [RW-1:0] r_res;
  logic          r_valid, r_err, r_arr_rst_n;
  logic          w_load, w_go, w_timeout, w_cap, w_ack;

  assign o_load_ready   = (r_state == IDLE);
  assign w_load         = i_load_valid & o_load_ready;
  assign o_busy         = (r_state == FEED) || (r_state == WAIT);
  assign o_err          = r_err;
  assign o_arr_reset_n  = r_arr_rst_n;
  assign o_inA          = r_inA;
  assign o_inB          = r_inB;
  assign o_result_out   = r_res;
  assign o_result_valid = r_valid;

  // Buffers as they will be after this cycle's write, so a load with start feeds new data
  always_comb begin
    w_a_nxt = r_a;
    w_b_nxt = r_b;
    if (w_load) begin
      for (int c = 0; c < N; c++) begin
        if (i_load_sel)
          w_b_nxt[i_load_row][2'(c)] = lane_get(i_load_data, c);
        else
          w_a_nxt[i_load_row][2'(c)] = lane_get(i_load_data, c);
      end
    end
  end

  // Next state and single-cycle event strobes
  always_comb begin
    w_next    = r_state;
    w_go      = 1'b0;
    w_timeout = 1'b0;
    w_cap     = 1'b0;
    w_ack     = 1'b0;
    unique case (r_state)
      IDLE: if (i_start) begin
        w_next = FEED;
        w_go   = 1'b1;
      end
      FEED: if (r_t == 3'(FEED_CYCLES - 1))
        w_next = WAIT;
      WAIT: if (i_arr_done) begin
        w_next = HOLD;
        w_cap  = 1'b1;
      end else if (r_wcnt == 4'(WAIT_MAX - 1)) begin
        w_next    = IDLE;
        w_timeout = 1'b1;
      end
      HOLD: if (i_result_ready) begin
        w_next = IDLE;
        w_ack  = 1'b1;
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_t_next = (r_state == FEED) ? r_t + 3'd1 : 3'd0;

  systolic_skew_mux #(.COL_MAJOR(1'b0)) u_mux_a (
    .i_t    (w_t_next),
    .i_m    (w_a_nxt),
    .o_word (w_skew_a)
  );

  systolic_skew_mux #(.COL_MAJOR(1'b1)) u_mux_b (
    .i_t    (w_t_next),
    .i_m    (w_b_nxt),
    .o_word (w_skew_b)
  );

  // Control state, registered array drive and result capture
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= IDLE;
      r_t         <= '0;
      r_wcnt      <= '0;
      r_inA       <= '0;
      r_inB       <= '0;
      r_arr_rst_n <= 1'b0;
      r_err       <= 1'b0;
      r_res       <= '0;
      r_valid     <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_t         <= w_t_next;
      r_wcnt      <= (r_state == WAIT) ? r_wcnt + 4'd1 : 4'd0;
      r_inA       <= (w_next == FEED) ? w_skew_a : '0;
      r_inB       <= (w_next == FEED) ? w_skew_b : '0;
      r_arr_rst_n <= (w_next == FEED) || (w_next == WAIT);
      if (w_go)
        r_err <= 1'b0;
      else if (w_timeout)
        r_err <= 1'b1;
      if (w_cap) begin
        r_res   <= i_result_in;
        r_valid <= 1'b1;
      end else if (w_ack) begin
        r_valid <= 1'b0;
      end
    end
  end

  // Operand buffers, written only while idle
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_a <= '{default: '0};
      r_b <= '{default: '0};
    end else begin
      r_a <= w_a_nxt;
      r_b <= w_b_nxt;
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: behavioural 4x4 output-stationary array,
// scoreboard of expected products, feed-word and protocol checks.
module tb_systolic_feeder;
  import systolic_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_valid, load_ready, load_sel;
  logic [1:0]    load_row;
  logic [31:0]   load_data;
  logic          start, busy, err, arr_rst_n;
  logic [31:0]   inA, inB;
  logic          arr_done;
  logic [127:0]  result_in, result_out;
  logic          result_valid, result_ready;

  int checks = 0;
  int errors = 0;
  logic [127:0] sb [$];

  logic [7:0] ma [4][4];
  logic [7:0] mb [4][4];

  logic [7:0] ah  [4][4];
  logic [7:0] bv  [4][4];
  logic [7:0] acc [4][4];
  logic [7:0] ain [4][4];
  logic [7:0] bin [4][4];
  int         acnt;
  bit         stuck;

  always #5 clk = ~clk;

  systolic_feeder dut (
    .i_clk          (clk),
    .i_reset        (rst_n),
    .i_load_valid   (load_valid),
    .o_load_ready   (load_ready),
    .i_load_sel     (load_sel),
    .i_load_row     (load_row),
    .i_load_data    (load_data),
    .i_start        (start),
    .o_busy         (busy),
    .o_err          (err),
    .o_arr_reset_n  (arr_rst_n),
    .o_inA          (inA),
    .o_inB          (inB),
    .i_arr_done     (arr_done),
    .i_result_in    (result_in),
    .o_result_out   (result_out),
    .o_result_valid (result_valid),
    .i_result_ready (result_ready)
  );

  always_comb begin
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ain[i][j] = (j == 0) ? inA[8*(3-i) +: 8] : ah[i][(j == 0) ? 0 : j-1];
        bin[i][j] = (i == 0) ? inB[8*(3-j) +: 8] : bv[(i == 0) ? 0 : i-1][j];
      end
  end

  always @(posedge clk) begin
    if (!arr_rst_n) begin
      acnt <= 0;
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          ah[i][j]  <= 8'h00;
          bv[i][j]  <= 8'h00;
          acc[i][j] <= 8'h00;
        end
    end else begin
      if (acnt < 15) acnt <= acnt + 1;
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          ah[i][j]  <= ain[i][j];
          bv[i][j]  <= bin[i][j];
          acc[i][j] <= acc[i][j] + 8'(ain[i][j] * bin[i][j]);
        end
    end
  end

  assign arr_done = (acnt == 10) && !stuck;

  always_comb begin
    for (int p = 0; p < 16; p++)
      result_in[8*(15-p) +: 8] = acc[p/4][p%4];
  end

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] matmul();
    logic [127:0] r;
    logic [7:0]   s;
    r = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        s = 8'h00;
        for (int k = 0; k < 4; k++)
          s = s + 8'(ma[i][k] * mb[k][j]);
        r[8*(15-(4*i+j)) +: 8] = s;
      end
    return r;
  endfunction

  function automatic logic [31:0] skew(input int t, input bit col);
    logic [31:0] w;
    int k;
    w = '0;
    for (int l = 0; l < 4; l++) begin
      k = t - l;
      if (k >= 0 && k < 4)
        w[8*(3-l) +: 8] = col ? mb[k][l] : ma[l][k];
    end
    return w;
  endfunction

  always @(negedge clk) begin
    #1;
    if (rst_n && result_valid && result_ready) begin
      if (sb.size() == 0)
        check("sb_underflow", sb.size(), 1);
      else
        check("result", result_out, sb.pop_front());
    end
  end

  task automatic load_row_t(input bit sel, input int r, input logic [31:0] d);
    load_valid = 1'b1;
    load_sel   = sel;
    load_row   = 2'(r);
    load_data  = d;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic load_all();
    for (int r = 0; r < 4; r++) begin
      load_row_t(1'b0, r, {ma[r][0], ma[r][1], ma[r][2], ma[r][3]});
      load_row_t(1'b1, r, {mb[r][0], mb[r][1], mb[r][2], mb[r][3]});
    end
  endtask

  task automatic fill(input logic [7:0] va, input logic [7:0] vb);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ma[i][j] = va;
        mb[i][j] = vb;
      end
  endtask

  task automatic run(input logic [127:0] exp, input bit bp);
    int n;
    logic [127:0] held;
    sb.push_back(exp);
    start = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    load_valid = 1'b0;
    check("err_clr", err, 0);
    check("busy", busy, 1);
    for (int t = 0; t < 7; t++) begin
      check("inA", inA, skew(t, 1'b0));
      check("inB", inB, skew(t, 1'b1));
      @(negedge clk);
    end
    n = 7;
    while (!result_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("latency", n, 11);
    if (bp) begin
      held = result_out;
      for (int c = 0; c < 20; c++) begin
        check("bp_valid", result_valid, 1);
        check("bp_hold", result_out, held);
        check("bp_ldrdy", load_ready, 0);
        start      = c[0];
        load_valid = c[0];
        load_sel   = 1'b0;
        load_row   = 2'd1;
        load_data  = 32'hDEADBEEF;
        @(negedge clk);
      end
      start        = 1'b0;
      load_valid   = 1'b0;
      result_ready = 1'b1;
    end
    @(negedge clk);
    check("idle_rdy", load_ready, 1);
    check("idle_vld", result_valid, 0);
    check("idle_busy", busy, 0);
  endtask

  task automatic check_reset_vals();
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_arst", arr_rst_n, 0);
    check("rst_inA", inA, 0);
    check("rst_inB", inB, 0);
    check("rst_rvld", result_valid, 0);
    check("rst_rout", result_out, 0);
    check("rst_ldrdy", load_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    bit sv;
    rst_n        = 1'b0;
    load_valid   = 1'b0;
    load_sel     = 1'b0;
    load_row     = 2'd0;
    load_data    = '0;
    start        = 1'b0;
    result_ready = 1'b1;
    stuck        = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals();

    fill(8'h00, 8'h00);
    for (int i = 0; i < 4; i++) begin
      ma[i][i] = 8'h01;
      for (int j = 0; j < 4; j++) mb[i][j] = 8'(4*i + j + 1);
    end
    load_all();
    run(128'h0102030405060708090A0B0C0D0E0F10, 1'b0);

    fill(8'h10, 8'h10);
    load_all();
    run(128'h0, 1'b0);

    fill(8'h01, 8'h01);
    load_all();
    run({16{8'h04}}, 1'b0);

    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ma[i][j] = 8'($urandom);
        mb[i][j] = 8'($urandom);
      end
    load_all();
    run(matmul(), 1'b0);

    result_ready = 1'b0;
    run(matmul(), 1'b1);
    run(matmul(), 1'b0);

    stuck = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n  = 0;
    sv = 1'b0;
    while (!err && n < 40) begin
      @(negedge clk);
      n++;
      sv |= result_valid;
    end
    check("to_cycles", n, 15);
    check("to_valid", sv, 0);
    check("to_busy", busy, 0);
    check("to_arst", arr_rst_n, 0);
    stuck = 1'b0;
    run(matmul(), 1'b0);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_inA", inA, skew(3, 1'b0));
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    @(negedge clk);
    rst_n = 1'b1;
    fill(8'h00, 8'h00);
    @(negedge clk);
    run(128'h0, 1'b0);

    fill(8'h01, 8'h01);
    load_all();
    load_valid = 1'b1;
    load_sel   = 1'b0;
    load_row   = 2'd0;
    load_data  = 32'hFF000000;
    ma[0][0] = 8'hFF;
    ma[0][1] = 8'h00;
    ma[0][2] = 8'h00;
    ma[0][3] = 8'h00;
    run(matmul(), 1'b0);

    repeat (2) @(negedge clk);
    check("sb_drain", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
